ddr3_pixel_unpack: RTL and testbench
====================================

# ddr3_pixel_unpack

Downstream stage of the DDR3 frame-read path: pops 128-bit words from the read-data FIFO that the DDR3 read engine fills and serialises them into 24-bit RGB pixels on demand from the VGA timing generator. Each word carries four 32-bit pixels, and the block emits one pixel per request cycle. It also enforces frame framing, signals frame completion, and flags FIFO underflow.

## Interface
- IMAGE_WIDTH, 1280, active pixels per line
- IMAGE_HEIGHT, 1024, active lines per frame
- UNDERFLOW_RGB, 24'hFF00FF, colour driven when no pixel is available
- clk  in  1  pixel clock; FIFO read side and VGA side share it
- reset  in  1  synchronous, active-high
- frame_start  in  1  single-cycle pulse at start of each frame
- pix_req  in  1  VGA requests one active pixel this cycle
- fifo_empty  in  1  read-data FIFO empty
- fifo_rd  out  1  FIFO pop; data valid the cycle after (non-show-ahead)
- fifo_rd_data  in  128  FIFO output word
- pix_data  out  24  RGB888, {R,G,B} = word[31:8] of the 32-bit pixel slot... lower byte discarded
- pix_valid  out  1  pix_data holds real image data
- frame_done  out  1  pulse with the last pixel of a frame
- frame_error  out  1  pulse when frame_start arrives mid-frame
- underflow  out  1  pulse when a request finds no pixel
- underflow_count  out  16  saturating underflow counter

## Operation
- Pixel order: slot 0 = word[31:0] first, slot 3 = word[127:96] last.
- Prefetch: two-entry word buffer (current, next). Assert fifo_rd when !fifo_empty and (held words + outstanding read) < 2. Prefetch runs in every state except during reset.
- States: IDLE (after reset; pix_req ignored, outputs idle) → RUN on frame_start. RUN → DONE when the pixel counter reaches IMAGE_WIDTH*IMAGE_HEIGHT−1 on a served request. DONE → RUN on frame_start. In RUN, frame_start → frame_error pulse, counter cleared, state stays RUN. Buffered data is not flushed.
- RUN with pix_req and the current word held: emit the slot and advance the slot index. On a 3→0 wrap, retire the current word and promote next. A word arriving in the same cycle fills the freed entry.
- RUN with pix_req and no current word: pix_data=UNDERFLOW_RGB, pix_valid=0, underflow=1, counter_advances. No data is consumed, so the image shifts by one pixel.
- frame_start and pix_req in the same cycle: the counter resets and the request is served as pixel 0 of the new frame. This holds in IDLE and DONE as well.
- pix_req in IDLE/DONE: pix_valid=0, pix_data=0, no underflow.
- Pixel counter width $clog2(IMAGE_WIDTH*IMAGE_HEIGHT). It never wraps, because DONE stops it.

## Timing
- pix_data/pix_valid/frame_done/underflow are registered, one cycle after the pix_req edge.
- FIFO read latency is 1 cycle. With both entries full, the block sustains pix_req every cycle indefinitely.
- Reset values: fifo_rd=0, pix_data=0, pix_valid=0, frame_done=0, frame_error=0, underflow=0, underflow_count=0. Buffer occupancy and slot index are 0, and the state is IDLE.
- Reset mid-read: a word returned the cycle after reset deasserts from a pre-reset pop is discarded. Outstanding-read tracking is cleared by reset.

## Configuration
- PIX_UNDERFLOW_STATS_EN defined: underflow_count increments on each underflow pulse and saturates at 16'hFFFF. It is cleared only by reset.
- Undefined: underflow_count is tied to 0 and no counter register is built. The underflow pulse is unaffected.

## Structure
- Shared package ddr3_video_pkg holds PIXELS_PER_WORD=4, WORD_W=128, PIXEL_W=32, and the IDLE/RUN/DONE state typedef.
- Sub-module unpack_word_buffer is the two-entry prefetch buffer with the fifo_rd/outstanding logic. It exposes cur_valid, cur_word and retire.

## Test plan
- FIFO preloaded with 2 words 0x…0004_0003_0002_0001 / …0008_0007_0006_0005, frame_start, 8 consecutive pix_req → pix_data slots 0x000000..0x000000 with source pixels 1..8 in order, pix_valid high 8 cycles, no underflow.
- IMAGE_WIDTH=4, IMAGE_HEIGHT=2 with full FIFO, 8 requests → frame_done on the 8th pixel. A 9th request → pix_valid=0, and pix_valid=0 continues until the next frame_start.
- Empty FIFO, frame_start, 3 pix_req → three UNDERFLOW_RGB outputs, underflow pulses ×3, underflow_count=3 (0 with the macro undefined).
- frame_start after 5 of 8 pixels → frame_error pulse, counter restarts, and frame_done arrives 8 served requests later.
- frame_start and pix_req in the same cycle from DONE → pixel served immediately with pix_valid=1 as pixel 0.
- Reset asserted one cycle after fifo_rd → all outputs at reset values, the late FIFO word is dropped, and the next frame starts from the next popped word.

Source files
------------

// File: rtl/ddr3_video_pkg.sv
// ============================================================================
// Module      : ddr3_video_pkg
// Description : Shared word/pixel geometry, state encoding and slot-to-RGB
//               extraction for the DDR3 frame-read video path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr3_video_pkg;

    localparam int PIXELS_PER_WORD = 4;
    localparam int WORD_W          = 128;
    localparam int PIXEL_W         = 32;
    localparam int RGB_W           = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } unpack_state_t;

    // The low byte of each 32-bit slot is padding; RGB lives in bits [31:8].
    function automatic logic [RGB_W-1:0] slot_rgb(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        slot);
        return word[PIXEL_W*int'(slot) + 8 +: RGB_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr3_pixel_unpack_word_buffer.sv
// ============================================================================
// Module      : unpack_word_buffer
// Description : Two-entry (current/next) prefetch buffer in front of a
//               non-show-ahead FIFO; keeps at most two words held or in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unpack_word_buffer
    import ddr3_video_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_o,
    input  logic [WORD_W-1:0] fifo_rd_data_i,
    input  logic              retire_i,
    output logic              cur_valid_o,
    output logic [WORD_W-1:0] cur_word_o
);

    logic [WORD_W-1:0] word_q [2];
    logic [WORD_W-1:0] word_d [2];
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;
    logic [1:0]        occ_ret;
    logic              pend_q;
    logic              rd;

    // Retire is not credited here, so a freed slot is refilled one cycle later;
    // the four-cycle slot period leaves ample time for that.
    assign rd = !reset && !fifo_empty_i && ((occ_q + {1'b0, pend_q}) < 2'd2);

    always_comb begin
        word_d[0] = word_q[0];
        word_d[1] = word_q[1];
        occ_ret   = occ_q;
        if (retire_i && (occ_q != 2'd0)) begin
            word_d[0] = word_q[1];
            occ_ret   = occ_q - 2'd1;
        end
        occ_d = occ_ret;
        if (pend_q) begin
            word_d[occ_ret[0]] = fifo_rd_data_i;
            occ_d              = occ_ret + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q  <= 2'd0;
            pend_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= rd;
        end
    end

    always_ff @(posedge clk) begin
        word_q[0] <= word_d[0];
        word_q[1] <= word_d[1];
    end

    assign fifo_rd_o   = rd;
    assign cur_valid_o = (occ_q != 2'd0);
    assign cur_word_o  = word_q[0];

endmodule

`default_nettype wire

// File: rtl/ddr3_pixel_unpack.sv
// ============================================================================
// Module      : ddr3_pixel_unpack
// Description : Serialises 128-bit FIFO words into RGB888 pixels on VGA demand,
//               with frame framing, completion and underflow reporting.
//               Optional macro PIX_UNDERFLOW_STATS_EN builds the underflow counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_pixel_unpack
    import ddr3_video_pkg::*;
#(
    parameter int          IMAGE_WIDTH   = 1280,
    parameter int          IMAGE_HEIGHT  = 1024,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_start,
    input  logic         pix_req,
    input  logic         fifo_empty,
    output logic         fifo_rd,
    input  logic [127:0] fifo_rd_data,
    output logic [23:0]  pix_data,
    output logic         pix_valid,
    output logic         frame_done,
    output logic         frame_error,
    output logic         underflow,
    output logic [15:0]  underflow_count
);

    localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(TOTAL - 1);
    localparam logic [1:0]       LAST_SLOT = 2'(PIXELS_PER_WORD - 1);

    unpack_state_t      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         slot_q;
    logic [RGB_W-1:0]   pix_data_q;
    logic               pix_valid_q;
    logic               frame_done_q;
    logic               frame_error_q;
    logic               underflow_q;

    logic               cur_valid;
    logic [WORD_W-1:0]  cur_word;
    logic               serve;
    logic               retire;
    logic [CNT_W-1:0]   pix_idx;

    // A frame_start coinciding with a request makes that request pixel 0.
    assign serve   = pix_req && ((state_q == ST_RUN) || frame_start);
    assign pix_idx = frame_start ? '0 : cnt_q;
    assign retire  = serve && cur_valid && (slot_q == LAST_SLOT);

    unpack_word_buffer u_buf (
        .clk            (clk),
        .reset          (reset),
        .fifo_empty_i   (fifo_empty),
        .fifo_rd_o      (fifo_rd),
        .fifo_rd_data_i (fifo_rd_data),
        .retire_i       (retire),
        .cur_valid_o    (cur_valid),
        .cur_word_o     (cur_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            slot_q        <= 2'd0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            underflow_q   <= 1'b0;

            if (frame_start) begin
                cnt_q   <= '0;
                state_q <= ST_RUN;
                if (state_q == ST_RUN) begin
                    frame_error_q <= 1'b1;
                end
            end

            if (serve) begin
                if (cur_valid) begin
                    pix_valid_q <= 1'b1;
                    pix_data_q  <= slot_rgb(cur_word, slot_q);
                    slot_q      <= slot_q + 2'd1;
                end else begin
                    // Nothing consumed: the image slips by one pixel.
                    pix_data_q  <= UNDERFLOW_RGB;
                    underflow_q <= 1'b1;
                end
                if (pix_idx == LAST_PIX) begin
                    frame_done_q <= 1'b1;
                    state_q      <= ST_DONE;
                    cnt_q        <= '0;
                end else begin
                    cnt_q <= pix_idx + CNT_W'(1);
                end
            end
        end
    end

`ifdef PIX_UNDERFLOW_STATS_EN
    logic [15:0] uf_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            uf_cnt_q <= 16'h0000;
        end else if (serve && !cur_valid && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_q <= uf_cnt_q + 16'h0001;
        end
    end

    assign underflow_count = uf_cnt_q;
`else
    assign underflow_count = 16'h0000;
`endif

    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign underflow   = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr3_pixel_unpack.sv
// ============================================================================
// Module      : tb_ddr3_pixel_unpack
// Description : Scoreboard bench for ddr3_pixel_unpack on a 4x2 image with a
//               queue-modelled non-show-ahead FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr3_pixel_unpack;

    typedef struct packed {
        logic        v;
        logic [23:0] d;
        logic        done;
        logic        err;
        logic        uf;
    } ev_t;

    typedef struct packed {
        logic        rd;
        logic        v;
        logic [23:0] d;
        logic        done;
        logic        err;
        logic        uf;
        logic [15:0] cnt;
    } snap_t;

`ifdef PIX_UNDERFLOW_STATS_EN
    localparam logic [15:0] EXP_UF3 = 16'd3;
`else
    localparam logic [15:0] EXP_UF3 = 16'd0;
`endif

    logic         clk;
    logic         reset;
    logic         frame_start;
    logic         pix_req;
    logic         fifo_empty;
    logic         fifo_rd;
    logic [127:0] fifo_rd_data;
    logic [23:0]  pix_data;
    logic         pix_valid;
    logic         frame_done;
    logic         frame_error;
    logic         underflow;
    logic [15:0]  underflow_count;

    logic [127:0] fq[$];
    ev_t          evq[$];
    snap_t        snapq[$];
    string        snap_name[$];
    int           total;
    int           bad;
    int           ev_no;
    logic         done;

    ddr3_pixel_unpack #(
        .IMAGE_WIDTH   (4),
        .IMAGE_HEIGHT  (2),
        .UNDERFLOW_RGB (24'hFF00FF)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .pix_req         (pix_req),
        .fifo_empty      (fifo_empty),
        .fifo_rd         (fifo_rd),
        .fifo_rd_data    (fifo_rd_data),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .frame_done      (frame_done),
        .frame_error     (frame_error),
        .underflow       (underflow),
        .underflow_count (underflow_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source pixel p carries RGB {10+p, 20+p, 40+p} and a junk low byte.
    function automatic logic [23:0] rgb(input int p);
        return {8'(8'h10 + p), 8'(8'h20 + p), 8'(8'h40 + p)};
    endfunction

    function automatic logic [127:0] mkword(input int p);
        logic [127:0] w;
        for (int s = 0; s < 4; s++) begin
            w[32*s +: 32] = {rgb(p + s), 8'(8'hA5 ^ (p + s))};
        end
        return w;
    endfunction

    task automatic push_px(input int p, input logic last);
        evq.push_back('{v: 1'b1, d: rgb(p), done: last, err: 1'b0, uf: 1'b0});
    endtask

    task automatic push_uf();
        evq.push_back('{v: 1'b0, d: 24'hFF00FF, done: 1'b0, err: 1'b0, uf: 1'b1});
    endtask

    task automatic push_err();
        evq.push_back('{v: 1'b0, d: 24'h000000, done: 1'b0, err: 1'b1, uf: 1'b0});
    endtask

    task automatic push_snap(input string name, input logic [15:0] cnt);
        snapq.push_back('{rd: 1'b0, v: 1'b0, d: 24'h0, done: 1'b0, err: 1'b0, uf: 1'b0, cnt: cnt});
        snap_name.push_back(name);
    endtask

    // One clock of stimulus; the FIFO model answers a pop one cycle later.
    task automatic step(input logic fs, input logic req);
        logic rd_s;
        frame_start = fs;
        pix_req     = req;
        fifo_empty  = (fq.size() == 0);
        #1;
        rd_s = fifo_rd;
        @(posedge clk);
        if (rd_s && fq.size() != 0) fifo_rd_data <= fq.pop_front();
        @(negedge clk);
        frame_start = 1'b0;
        pix_req     = 1'b0;
    endtask

    initial begin
        done         = 1'b0;
        reset        = 1'b1;
        frame_start  = 1'b0;
        pix_req      = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        @(negedge clk);
        fq.push_back(mkword(1));
        fq.push_back(mkword(5));
        step(0, 0);
        step(0, 0);
        push_snap("reset_state", 16'd0);
        step(0, 0);
        reset = 1'b0;
        repeat (4) step(0, 0);

        // Full frame from two preloaded words; frame_done on pixel 8.
        step(1, 0);
        for (int p = 1; p <= 8; p++) begin
            push_px(p, p == 8);
            step(0, 1);
        end
        push_snap("done_ignores_req", 16'd0);
        step(0, 1);
        step(0, 1);

        // Empty FIFO: frame_start+req from DONE then two more requests underflow.
        for (int i = 0; i < 3; i++) begin
            push_uf();
            step(i == 0, 1);
        end
        step(0, 0);
        push_snap("underflow_count", EXP_UF3);
        step(0, 0);

        // frame_start mid-frame, then again after 5 pixels; done 8 later.
        fq.push_back(mkword(9));
        fq.push_back(mkword(13));
        fq.push_back(mkword(17));
        fq.push_back(mkword(21));
        repeat (4) step(0, 0);
        push_err();
        step(1, 0);
        for (int p = 9; p <= 13; p++) begin
            push_px(p, 1'b0);
            step(0, 1);
        end
        push_err();
        step(1, 0);
        for (int p = 14; p <= 21; p++) begin
            push_px(p, p == 21);
            step(0, 1);
        end

        // frame_start with request from DONE serves pixel 0 immediately.
        fq.push_back(mkword(25));
        fq.push_back(mkword(29));
        repeat (3) step(0, 0);
        push_px(22, 1'b0);
        step(1, 1);
        for (int p = 23; p <= 29; p++) begin
            push_px(p, p == 29);
            step(0, 1);
        end

        // Reset the cycle after a pop: the returning word must be dropped.
        fq.push_back(mkword(33));
        fq.push_back(mkword(37));
        fq.push_back(mkword(41));
        step(0, 0);
        reset = 1'b1;
        push_snap("reset_midread", 16'd0);
        step(0, 0);
        reset = 1'b0;
        repeat (3) step(0, 0);
        push_px(37, 1'b0);
        step(1, 1);
        for (int p = 38; p <= 40; p++) begin
            push_px(p, 1'b0);
            step(0, 1);
        end
        repeat (2) step(0, 0);
        done = 1'b1;
    end

    initial begin
        snap_t s;
        snap_t sa;
        ev_t   e;
        ev_t   ea;
        string nm;
        total = 0;
        bad   = 0;
        ev_no = 0;
        forever begin
            @(posedge clk);
            #2;
            if (snapq.size() != 0) begin
                s  = snapq.pop_front();
                nm = snap_name.pop_front();
                sa = '{rd: fifo_rd, v: pix_valid, d: pix_data, done: frame_done,
                       err: frame_error, uf: underflow, cnt: underflow_count};
                total++;
                if (sa !== s) begin
                    bad++;
                    $display("FAIL snap_%s: got rd=%b v=%b d=%h done=%b err=%b uf=%b cnt=%0d, want rd=%b v=%b d=%h done=%b err=%b uf=%b cnt=%0d",
                             nm, sa.rd, sa.v, sa.d, sa.done, sa.err, sa.uf, sa.cnt,
                             s.rd, s.v, s.d, s.done, s.err, s.uf, s.cnt);
                end
            end
            if (pix_valid || underflow || frame_done || frame_error) begin
                ea = '{v: pix_valid, d: pix_data, done: frame_done, err: frame_error, uf: underflow};
                total++;
                if (evq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: got v=%b d=%h done=%b err=%b uf=%b, want no output",
                             ea.v, ea.d, ea.done, ea.err, ea.uf);
                end else begin
                    e = evq.pop_front();
                    if (ea !== e) begin
                        bad++;
                        $display("FAIL event_%0d: got v=%b d=%h done=%b err=%b uf=%b, want v=%b d=%h done=%b err=%b uf=%b",
                                 ev_no, ea.v, ea.d, ea.done, ea.err, ea.uf, e.v, e.d, e.done, e.err, e.uf);
                    end
                    ev_no++;
                end
            end
            if (done) begin
                total++;
                if (evq.size() != 0 || snapq.size() != 0) begin
                    bad++;
                    $display("FAIL missing_outputs: got %0d events and %0d snaps unconsumed, want 0",
                             evq.size(), snapq.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
